if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of the program counter. Takes the current
//  PC value, fetches the 16-bit instruction over a req/ack instruction-memory handshake and

---
 rtl/if_fetch_unit.sv | 130 +++++++++++++
 tb/tb_if_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues one imem request at a time for the current PC,
// buffers returned {pc, instr} pairs in a small circular queue for decode, and
// discards any fetch that a redirect has made stale.
module if_fetch_unit #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               redirect,
  output logic               pc_step,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               id_ready
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [CntW-1:0] QDepthC = CntW'(QDEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } state_e;

  state_e state_q;

  logic [INSTR_W-1:0] mem_instr_q [QDEPTH];
  logic [ADDR_W-1:0]  mem_pc_q    [QDEPTH];
  logic [PtrW-1:0]    wr_ptr_q;
  logic [PtrW-1:0]    rd_ptr_q;
  logic [CntW-1:0]    count_q;

  logic push;
  logic pop;
  logic can_issue;

  // Only a live (non-redirected) ack in WAIT captures data; DROP acks are discarded.
  assign push      = (state_q == StWait) && imem_ack && !redirect;
  // Flush wins over a pop in the redirect cycle.
  assign pop       = id_valid && id_ready && !redirect;
  // Gating issue on a free slot guarantees the eventual push never overflows.
  assign can_issue = !redirect && (count_q < QDepthC);

  assign pc_step  = push;
  assign id_valid = (count_q != '0);
  assign id_instr = id_valid ? mem_instr_q[rd_ptr_q] : '0;
  assign id_pc    = id_valid ? mem_pc_q[rd_ptr_q] : '0;

  // Fetch FSM with registered request/address; at most one request outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (can_issue) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state_q   <= StWait;
          end else begin
            imem_req <= 1'b0;
          end
        end
        StWait: begin
          if (imem_ack) begin
            // Captured or, if redirected this cycle, silently dropped.
            imem_req <= 1'b0;
            state_q  <= StIdle;
          end else if (redirect) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          // Request cannot be cancelled; wait out the stale ack.
          if (imem_ack) begin
            imem_req <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  // Circular fetch queue; redirect flushes everything at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_instr_q[wr_ptr_q] <= imem_rdata;
        mem_pc_q[wr_ptr_q]    <= imem_addr;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, straight fetch, backpressure, redirects
// and queue pointer wrap, with hand-computed expected values.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic        redirect;
  logic        pc_step;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        id_ready;

  int n_chk;
  int n_pass;

  if_fetch_unit #(
    .ADDR_W (16),
    .INSTR_W(16),
    .QDEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .redirect  (redirect),
    .pc_step   (pc_step),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .id_ready  (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its address, ack it with data.
  task automatic fetch(input logic [15:0] addr, input logic [15:0] data);
    pc = addr;
    for (int i = 0; i < 8; i++) begin
      if (imem_req) break;
      cyc();
    end
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    #1;
    chk("fetch_step", pc_step, 1);
    cyc();
    imem_ack = 1'b0;
  endtask

  task automatic pop(input logic [15:0] exp_pc, input logic [15:0] exp_instr);
    chk("pop_valid", id_valid, 1);
    chk("pop_pc", id_pc, exp_pc);
    chk("pop_instr", id_instr, exp_instr);
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    pc         = 16'h0100;
    redirect   = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    id_ready   = 1'b0;

    // Reset, then async reset in the middle of a WAIT.
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_idpc", id_pc, 0);
    chk("rst_step", pc_step, 0);
    cyc();
    chk("a_req", imem_req, 1);
    chk("a_addr", imem_addr, 16'h0100);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", imem_req, 0);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_valid", id_valid, 0);
    imem_ack   = 1'b1;
    imem_rdata = 16'h5555;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("late_ack_step", pc_step, 0);
    cyc();
    chk("late_ack_valid", id_valid, 0);
    imem_ack = 1'b0;
    #1;
    chk("a_wait_req", imem_req, 1);
    imem_ack   = 1'b1;
    imem_rdata = 16'h1111;
    #1;
    chk("a_step", pc_step, 1);
    cyc();
    imem_ack = 1'b0;
    chk("a_valid", id_valid, 1);
    chk("a_idpc", id_pc, 16'h0100);
    chk("a_instr", id_instr, 16'h1111);
    redirect = 1'b1;
    cyc();
    chk("a_flush", id_valid, 0);

    // Straight fetch at 0x0000.
    redirect = 1'b0;
    pc       = 16'h0000;
    cyc();
    chk("b_req", imem_req, 1);
    chk("b_addr", imem_addr, 16'h0000);
    chk("b_valid0", id_valid, 0);
    imem_ack   = 1'b1;
    imem_rdata = 16'hA123;
    #1;
    chk("b_step", pc_step, 1);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("b_req_low", imem_req, 0);
    chk("b_step_off", pc_step, 0);
    chk("b_valid", id_valid, 1);
    chk("b_instr", id_instr, 16'hA123);
    chk("b_idpc", id_pc, 16'h0000);
    redirect = 1'b1;
    cyc();
    chk("b_flush", id_valid, 0);

    // Backpressure: fill the queue, then a single pop re-opens issue.
    redirect = 1'b0;
    pc       = 16'h0010;
    cyc();
    chk("c_addr0", imem_addr, 16'h0010);
    imem_ack   = 1'b1;
    imem_rdata = 16'h0C10;
    cyc();
    imem_ack = 1'b0;
    pc       = 16'h0011;
    cyc();
    chk("c_req1", imem_req, 1);
    chk("c_addr1", imem_addr, 16'h0011);
    imem_ack   = 1'b1;
    imem_rdata = 16'h0C11;
    cyc();
    imem_ack = 1'b0;
    chk("c_head_pc", id_pc, 16'h0010);
    chk("c_head_instr", id_instr, 16'h0C10);
    cyc();
    chk("c_full_noreq", imem_req, 0);
    pc       = 16'h0012;
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    chk("c_pop_pc", id_pc, 16'h0011);
    chk("c_pop_instr", id_instr, 16'h0C11);
    chk("c_pop_noreq", imem_req, 0);
    cyc();
    chk("c_reissue_req", imem_req, 1);
    chk("c_reissue_addr", imem_addr, 16'h0012);
    imem_ack   = 1'b1;
    imem_rdata = 16'h0C12;
    cyc();
    imem_ack = 1'b0;
    redirect = 1'b1;
    cyc();
    chk("c_flush", id_valid, 0);

    // Redirect in WAIT: stale ack dropped, fresh request at the new pc.
    redirect = 1'b0;
    pc       = 16'h0020;
    cyc();
    chk("d_req", imem_req, 1);
    chk("d_addr", imem_addr, 16'h0020);
    redirect = 1'b1;
    pc       = 16'h0040;
    #1;
    chk("d_redir_step", pc_step, 0);
    cyc();
    chk("d_drop_req", imem_req, 1);
    chk("d_drop_addr", imem_addr, 16'h0020);
    cyc();
    redirect = 1'b0;
    chk("d_drop_hold", imem_req, 1);
    cyc();
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    #1;
    chk("d_drop_step", pc_step, 0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("d_drop_valid", id_valid, 0);
    chk("d_drop_idle", imem_req, 0);
    cyc();
    chk("d_new_req", imem_req, 1);
    chk("d_new_addr", imem_addr, 16'h0040);
    imem_ack   = 1'b1;
    imem_rdata = 16'h4040;
    cyc();
    imem_ack = 1'b0;
    chk("d_new_instr", id_instr, 16'h4040);

    // Redirect together with ack and pop, one entry queued.
    pc = 16'h0041;
    cyc();
    chk("e_req", imem_req, 1);
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    redirect   = 1'b1;
    id_ready   = 1'b1;
    #1;
    chk("e_step", pc_step, 0);
    cyc();
    imem_ack = 1'b0;
    id_ready = 1'b0;
    redirect = 1'b0;
    #1;
    chk("e_valid", id_valid, 0);
    chk("e_instr", id_instr, 0);
    chk("e_idle", imem_req, 0);

    // Pointer wrap with interleaved pops; includes the 0xFFFF address.
    fetch(16'h0100, 16'h1000);
    fetch(16'h0101, 16'h1001);
    pop(16'h0100, 16'h1000);
    fetch(16'h0102, 16'h1002);
    pop(16'h0101, 16'h1001);
    fetch(16'h0200, 16'h2000);
    pop(16'h0102, 16'h1002);
    fetch(16'hFFFF, 16'h7FFF);
    pop(16'h0200, 16'h2000);
    fetch(16'h0000, 16'h0001);
    pop(16'hFFFF, 16'h7FFF);
    pop(16'h0000, 16'h0001);
    chk("f_empty", id_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
